// File: rtl/fp_norm_pack.sv
// fp_norm_pack: normalises a raw FP-adder sum one shift per cycle and packs
// it into an IEEE-754 word (truncation, denormals flushed to zero).
// Ports:
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_in_valid / o_in_ready       : raw sum handshake (ready only in IDLE)
//   i_in_sign, i_in_exp, i_in_frac: sign, biased exp, {carry, hidden, man}
//   o_out_valid / i_out_ready     : packed result handshake
//   o_out_result                  : packed {sign, exp, mantissa}
module fp_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_in_sign,
  input  logic [EXP_W-1:0]       i_in_exp,
  input  logic [MAN_W+1:0]       i_in_frac,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [EXP_W+MAN_W:0]   o_out_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_SAT = EXP_INF - EXP_ONE;

  state_t                 r_state, w_state;
  logic                   r_sign, w_sign;
  logic [EXP_W:0]         r_exp, w_exp;
  logic [MAN_W+1:0]       r_frac, w_frac;
  logic [EXP_W+MAN_W:0]   r_result, w_result;

  logic [EXP_W+MAN_W:0]   w_inf_word;
  logic [EXP_W+MAN_W:0]   w_zero_word;

  assign w_inf_word  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign w_zero_word = {r_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};

  always_comb begin
    w_state  = r_state;
    w_sign   = r_sign;
    w_exp    = r_exp;
    w_frac   = r_frac;
    w_result = r_result;
    unique case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_sign  = i_in_sign;
          w_exp   = {1'b0, i_in_exp};
          w_frac  = i_in_frac;
          w_state = NORM;
        end
      end
      NORM: begin
        // Priority order matters: an all-ones input exponent wins over
        // everything, zero wins over the carry/hidden checks.
        if (r_exp == EXP_INF) begin
          w_result = w_inf_word;
          w_state  = DONE;
        end else if (r_frac == '0) begin
          w_result = w_zero_word;
          w_state  = DONE;
        end else if (r_frac[MAN_W+1]) begin
          if (r_exp >= EXP_SAT) begin
            w_result = w_inf_word;
            w_state  = DONE;
          end else begin
            w_frac = r_frac >> 1;
            w_exp  = r_exp + EXP_ONE;
          end
        end else if (r_frac[MAN_W]) begin
          w_result = {r_sign, r_exp[EXP_W-1:0], r_frac[MAN_W-1:0]};
          w_state  = DONE;
        end else begin
          // Exponent would reach the denormal range: flush to zero.
          if (r_exp <= EXP_ONE) begin
            w_result = w_zero_word;
            w_state  = DONE;
          end else begin
            w_frac = r_frac << 1;
            w_exp  = r_exp - EXP_ONE;
          end
        end
      end
      DONE: begin
        if (i_out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state;
      r_sign   <= w_sign;
      r_exp    <= w_exp;
      r_frac   <= w_frac;
      r_result <= w_result;
    end
  end

  assign o_in_ready   = (r_state == IDLE);
  assign o_out_valid  = (r_state == DONE);
  assign o_out_result = r_result;

endmodule

// File: tb/tb_fp_norm_pack.sv
// tb_fp_norm_pack: directed vectors for fp_norm_pack with hand-computed
// packed results and latencies.
module tb_fp_norm_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int n_tests;
  int n_fail;

  fp_norm_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_sign    (in_sign),
    .i_in_exp     (in_exp),
    .i_in_frac    (in_frac),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operand, measures latency from the accept edge to the
  // first edge at which out_valid is high, then optionally releases it.
  task automatic run_op(input string tag, input logic s,
                        input logic [7:0] e, input logic [24:0] f,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit release_out);
    int n;
    bit rdy_seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_frac  = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    do begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, out_result, exp_res);
    check({tag, " latency"}, n + 1, exp_lat);
    check({tag, " in_ready low"}, 32'(rdy_seen), 32'd0);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] held;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_frac   = '0;
    out_ready = 1'b0;
    #7;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("norm1.5", 1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 2, 1'b1);
    run_op("carry2.0", 1'b0, 8'h7F, 25'h1000000, 32'h40000000, 3, 1'b1);
    run_op("carryFE", 1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 2, 1'b1);
    run_op("expFF", 1'b0, 8'hFF, 25'h1000000, 32'h7F800000, 2, 1'b1);
    run_op("left3", 1'b0, 8'h82, 25'h0100000, 32'h3F800000, 5, 1'b1);
    run_op("negzero", 1'b1, 8'h7F, 25'h0000000, 32'h80000000, 2, 1'b1);
    run_op("uflow", 1'b0, 8'h01, 25'h0400000, 32'h00000000, 2, 1'b1);
    run_op("left23", 1'b0, 8'h90, 25'h0000001, 32'h3C800000, 25, 1'b1);
    run_op("negman", 1'b1, 8'h80, 25'h0A00001, 32'hC0200001, 2, 1'b0);

    // Backpressure: result must hold while a new operand is offered.
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'h7F;
      in_frac  = 25'h0C00000;
      @(posedge clk);
      #1;
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp result", out_result, held);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp release ready", 32'(in_ready), 32'd1);
    check("bp release result", out_result, held);

    run_op("after bp", 1'b0, 8'h81, 25'h0800000, 32'h40800000, 2, 1'b1);

    // Reset in the 5th NORM cycle of a long left-shift operand.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h90;
    in_frac  = 25'h0000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre-rst result", out_result, 32'h40800000);
    rst_n = 1'b0;
    #1;
    check("arst valid", 32'(out_valid), 32'd0);
    check("arst ready", 32'(in_ready), 32'd1);
    check("arst result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post rst", 1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
